// File: rtl/ps2_key_state_decoder_pkg.sv
// Shared constants for the PS/2 key-state decoder: key indices, special
// scan-code bytes and parser state encodings.
package ps2_key_state_decoder_pkg;

  localparam int NUMBER_OF_KEYBOARD_INPUTS = 16;

  // Key indices into inputStateStorage
  localparam int KEY_SPACEBAR  = 0;
  localparam int KEY_BACKSLASH = 1;
  localparam int KEY_R         = 2;
  localparam int KEY_PIANO_A   = 3;   // 1C
  localparam int KEY_PIANO_W   = 4;   // 1D
  localparam int KEY_PIANO_S   = 5;   // 1B
  localparam int KEY_PIANO_E   = 6;   // 24
  localparam int KEY_PIANO_D   = 7;   // 23
  localparam int KEY_PIANO_F   = 8;   // 2B
  localparam int KEY_PIANO_T   = 9;   // 2C
  localparam int KEY_PIANO_G   = 10;  // 34
  localparam int KEY_PIANO_Y   = 11;  // 35
  localparam int KEY_PIANO_H   = 12;  // 33
  localparam int KEY_PIANO_U   = 13;  // 3C
  localparam int KEY_PIANO_J   = 14;  // 3B
  localparam int KEY_PIANO_K   = 15;  // 42

  // Special bytes in the PS/2 stream
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_OVR_LO = 8'h00;
  localparam logic [7:0] SC_OVR_HI = 8'hFF;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;

  // Bytes following E1 in the pause sequence
  localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BRK    = 3'd1,
    ST_EXT    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_PAUSE  = 3'd4
  } parse_state_e;

endpackage

// File: rtl/ps2_key_state_decoder_scancode_to_key_index.sv
// Combinational lookup from (extended flag, scan code) to a key index.
module scancode_to_key_index
  import ps2_key_state_decoder_pkg::*;
#(
  parameter int NUM_KEYS = NUMBER_OF_KEYBOARD_INPUTS,
  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic          ext,
  input  logic [7:0]    code,
  output logic          hit,
  output logic [IW-1:0] index
);

  int k;

  // Fixed table; E0-prefixed codes are kept distinct and none are mapped.
  always_comb begin
    k = -1;
    case ({ext, code})
      9'h029: k = KEY_SPACEBAR;
      9'h05D: k = KEY_BACKSLASH;
      9'h02D: k = KEY_R;
      9'h01C: k = KEY_PIANO_A;
      9'h01D: k = KEY_PIANO_W;
      9'h01B: k = KEY_PIANO_S;
      9'h024: k = KEY_PIANO_E;
      9'h023: k = KEY_PIANO_D;
      9'h02B: k = KEY_PIANO_F;
      9'h02C: k = KEY_PIANO_T;
      9'h034: k = KEY_PIANO_G;
      9'h035: k = KEY_PIANO_Y;
      9'h033: k = KEY_PIANO_H;
      9'h03C: k = KEY_PIANO_U;
      9'h03B: k = KEY_PIANO_J;
      9'h042: k = KEY_PIANO_K;
      default: k = -1;
    endcase
  end

  // Keys beyond a narrowed NUM_KEYS simply miss
  assign hit   = (k >= 0) && (k < NUM_KEYS);
  assign index = IW'(k);

endmodule

// File: rtl/ps2_key_state_decoder.sv
// PS/2 byte-stream parser: make/break/E0 handling, pause-sequence skip,
// prefix timeout and overrun recovery, producing held-key state and
// one-cycle new-press pulses.
module ps2_key_state_decoder
  import ps2_key_state_decoder_pkg::*;
#(
  parameter int NUM_KEYS       = NUMBER_OF_KEYBOARD_INPUTS,
  parameter int PREFIX_TIMEOUT = 2_500_000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          scanCode,
  input  logic                scanCodeValid,
  output logic [NUM_KEYS-1:0] inputStateStorage,
  output logic [NUM_KEYS-1:0] newPress,
  output logic                sequenceError
);

  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

  parse_state_e        state_q, state_d;
  logic [2:0]          pause_q, pause_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic [NUM_KEYS-1:0] np_q, np_d;
  logic                err_q, err_d;

  logic          map_ext;
  logic          map_hit;
  logic [IW-1:0] map_idx;

  assign map_ext = (state_q == ST_EXT) || (state_q == ST_EXTBRK);

  scancode_to_key_index #(.NUM_KEYS(NUM_KEYS)) u_map (
    .ext   (map_ext),
    .code  (scanCode),
    .hit   (map_hit),
    .index (map_idx)
  );

  // Next-state: a byte always takes precedence over timeout expiry
  always_comb begin
    state_d = state_q;
    pause_d = pause_q;
    tmo_d   = tmo_q;
    keys_d  = keys_q;
    np_d    = '0;
    err_d   = 1'b0;
    if (scanCodeValid) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          case (scanCode)
            SC_BREAK: state_d = ST_BRK;
            SC_EXT:   state_d = ST_EXT;
            SC_PAUSE: begin
              state_d = ST_PAUSE;
              pause_d = PAUSE_TAIL_LEN;
            end
            SC_OVR_LO, SC_OVR_HI: begin
              keys_d = '0;
              err_d  = 1'b1;
            end
            SC_BAT, SC_ACK, SC_RESEND, SC_ECHO: ;
            default: if (map_hit) begin
              keys_d[map_idx] = 1'b1;
              np_d[map_idx]   = ~keys_q[map_idx];
            end
          endcase
        end
        ST_EXT: begin
          if (scanCode == SC_BREAK) begin
            state_d = ST_EXTBRK;
          end else begin
            state_d = ST_IDLE;
            if (map_hit) begin
              keys_d[map_idx] = 1'b1;
              np_d[map_idx]   = ~keys_q[map_idx];
            end
          end
        end
        ST_BRK, ST_EXTBRK: begin
          state_d = ST_IDLE;
          if (map_hit) keys_d[map_idx] = 1'b0;
        end
        ST_PAUSE: begin
          if (pause_q <= 3'd1) begin
            state_d = ST_IDLE;
            pause_d = '0;
          end else begin
            pause_d = pause_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        pause_d = '0;
        tmo_d   = '0;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Parser state and registered outputs
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= ST_IDLE;
      pause_q <= '0;
      tmo_q   <= '0;
      keys_q  <= '0;
      np_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pause_q <= pause_d;
      tmo_q   <= tmo_d;
      keys_q  <= keys_d;
      np_q    <= np_d;
      err_q   <= err_d;
    end
  end

  assign inputStateStorage = keys_q;
  assign newPress          = np_q;
  assign sequenceError     = err_q;

endmodule

// File: tb/tb_ps2_key_state_decoder.sv
// Table-driven bench with a scoreboard queue for the PS/2 key-state decoder.
module tb_ps2_key_state_decoder;
  import ps2_key_state_decoder_pkg::*;

  localparam int NK  = 16;
  localparam int TMO = 16;

  localparam logic [NK-1:0] SPC = NK'(1) << KEY_SPACEBAR;
  localparam logic [NK-1:0] BSL = NK'(1) << KEY_BACKSLASH;
  localparam logic [NK-1:0] RK  = NK'(1) << KEY_R;
  localparam logic [NK-1:0] Z   = '0;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [7:0]    scanCode = 8'h00;
  logic          scanCodeValid = 1'b0;
  logic [NK-1:0] inputStateStorage;
  logic [NK-1:0] newPress;
  logic          sequenceError;

  ps2_key_state_decoder #(.NUM_KEYS(NK), .PREFIX_TIMEOUT(TMO)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .scanCode          (scanCode),
    .scanCodeValid     (scanCodeValid),
    .inputStateStorage (inputStateStorage),
    .newPress          (newPress),
    .sequenceError     (sequenceError)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          r;
    logic          v;
    logic [7:0]    c;
    logic [NK-1:0] k;
    logic [NK-1:0] np;
    logic          e;
  } vec_t;

  typedef struct packed {
    logic [NK-1:0] k;
    logic [NK-1:0] np;
    logic          e;
    int            id;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;

  // Drive one cycle of stimulus and queue what must appear after the edge
  task automatic step(input logic r, input logic v, input logic [7:0] c,
                      input logic [NK-1:0] k, input logic [NK-1:0] np,
                      input logic e);
    exp_t x;
    @(negedge clk);
    resetn        = r;
    scanCodeValid = v;
    scanCode      = c;
    x.k = k; x.np = np; x.e = e; x.id = step_id;
    sb.push_back(x);
    step_id++;
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] c,
                     input logic [NK-1:0] k, input logic [NK-1:0] np,
                     input logic e);
    vec_t t;
    t.r = r; t.v = v; t.c = c; t.k = k; t.np = np; t.e = e;
    tbl.push_back(t);
  endtask

  // Compare registered outputs just after each active edge
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_checks++;
      if (inputStateStorage === x.k) n_pass++;
      else $display("FAIL state step %0d: got %h want %h", x.id, inputStateStorage, x.k);
      n_checks++;
      if (newPress === x.np) n_pass++;
      else $display("FAIL newPress step %0d: got %h want %h", x.id, newPress, x.np);
      n_checks++;
      if (sequenceError === x.e) n_pass++;
      else $display("FAIL seqErr step %0d: got %b want %b", x.id, sequenceError, x.e);
    end
  end

  initial begin
    // reset
    add(1, 0, 8'h00, Z, Z, 0);
    add(1, 1, 8'h29, Z, Z, 0);            // bytes ignored during reset
    add(0, 0, 8'h00, Z, Z, 0);
    // spacebar make, idle, break
    add(0, 1, 8'h29, SPC, SPC, 0);
    add(0, 0, 8'h00, SPC, Z, 0);
    add(0, 1, 8'hF0, SPC, Z, 0);
    add(0, 1, 8'h29, Z, Z, 0);
    // typematic R
    add(0, 1, 8'h2D, RK, RK, 0);
    add(0, 1, 8'h2D, RK, Z, 0);
    add(0, 1, 8'h2D, RK, Z, 0);
    add(0, 1, 8'hF0, RK, Z, 0);
    add(0, 1, 8'h2D, Z, Z, 0);
    // E0-prefixed spacebar is a different key; plain spacebar untouched
    add(0, 1, 8'h29, SPC, SPC, 0);
    add(0, 1, 8'hE0, SPC, Z, 0);
    add(0, 1, 8'h29, SPC, Z, 0);
    add(0, 1, 8'hE0, SPC, Z, 0);
    add(0, 1, 8'hF0, SPC, Z, 0);
    add(0, 1, 8'h29, SPC, Z, 0);
    // ignored control bytes
    add(0, 1, 8'hAA, SPC, Z, 0);
    add(0, 1, 8'hFA, SPC, Z, 0);
    // backslash then pause sequence, then R proves parser is back in IDLE
    add(0, 1, 8'h5D, SPC|BSL, BSL, 0);
    add(0, 1, 8'hE1, SPC|BSL, Z, 0);
    add(0, 1, 8'h14, SPC|BSL, Z, 0);
    add(0, 1, 8'h77, SPC|BSL, Z, 0);
    add(0, 1, 8'hE1, SPC|BSL, Z, 0);
    add(0, 1, 8'hF0, SPC|BSL, Z, 0);
    add(0, 1, 8'h14, SPC|BSL, Z, 0);
    add(0, 1, 8'hF0, SPC|BSL, Z, 0);
    add(0, 1, 8'h77, SPC|BSL, Z, 0);
    add(0, 1, 8'h2D, SPC|BSL|RK, RK, 0);
    // overrun clears everything, no newPress
    add(0, 1, 8'hFF, Z, Z, 1);
    add(0, 0, 8'h00, Z, Z, 0);
    add(0, 1, 8'h29, SPC, SPC, 0);
    add(0, 1, 8'h00, Z, Z, 1);
    // reset between F0 and 29: 29 becomes a make
    add(0, 1, 8'h2D, RK, RK, 0);
    add(0, 1, 8'hF0, RK, Z, 0);
    add(1, 0, 8'h00, Z, Z, 0);
    add(0, 1, 8'h29, SPC, SPC, 0);
    add(0, 1, 8'hF0, SPC, Z, 0);
    add(0, 1, 8'h29, Z, Z, 0);

    foreach (tbl[i])
      step(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].k, tbl[i].np, tbl[i].e);

    // Prefix timeout: F0 then TMO idle cycles, error on the last one
    step(0, 1, 8'hF0, Z, Z, 0);
    for (int i = 0; i < TMO; i++)
      step(0, 0, 8'h00, Z, Z, (i == TMO - 1));
    step(0, 1, 8'h29, SPC, SPC, 0);         // make, not break
    step(0, 0, 8'h00, SPC, Z, 0);

    // Byte arrives on the expiry cycle: byte wins, break applied, no error
    step(0, 1, 8'hF0, SPC, Z, 0);
    for (int i = 0; i < TMO - 1; i++)
      step(0, 0, 8'h00, SPC, Z, 0);
    step(0, 1, 8'h29, Z, Z, 0);
    step(0, 0, 8'h00, Z, Z, 0);

    // Timeout out of a pause sequence, then normal make
    step(0, 1, 8'hE1, Z, Z, 0);
    step(0, 1, 8'h14, Z, Z, 0);
    for (int i = 0; i < TMO; i++)
      step(0, 0, 8'h00, Z, Z, (i == TMO - 1));
    step(0, 1, 8'h5D, BSL, BSL, 0);

    @(negedge clk);
    scanCodeValid = 1'b0;
    @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_state_decoder.md
# ps2_key_state_decoder

Converts the PS/2 keyboard byte stream into the per-key held-state vector `inputStateStorage` that the master FSM and note logic consume. It sits between the PS/2 receiver, which delivers one byte per valid strobe, and the master FSM. It tracks make, break and E0-extended prefixes, and discards the pause sequence. It also emits a one-cycle new-press pulse per key.

## Interface
- `NUM_KEYS`, default `` `NUMBEROFKEYBOARDINPUTS ``: width of the key vectors.
- `PREFIX_TIMEOUT`, default 2_500_000: idle cycles (50 ms at 50 MHz) after which a pending prefix is abandoned.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `resetn`  in  1: synchronous, active-high reset (1 = reset).
- `scanCode`  in  8: received PS/2 byte, valid only when `scanCodeValid`=1.
- `scanCodeValid`  in  1: one-cycle strobe per byte; may be asserted on consecutive cycles.
- `inputStateStorage`  out  NUM_KEYS: bit k = 1 while key k is held.
- `newPress`  out  NUM_KEYS: bit k pulses for one cycle on a 0→1 transition of bit k.
- `sequenceError`  out  1: one-cycle pulse on overrun byte or prefix timeout.

## Operation
- Reset values:
  - `inputStateStorage`=0, `newPress`=0, `sequenceError`=0.
  - Parser state = IDLE, pause counter = 0, timeout counter = 0.
- Parser states: IDLE, BRK (F0 seen), EXT (E0 seen), EXTBRK (E0 F0 seen), PAUSE (skipping bytes). Only cycles with `scanCodeValid`=1 advance the parser.
- From IDLE:
  - F0→BRK.
  - E0→EXT.
  - E1→PAUSE, with pause counter loaded to 7.
  - 00 or FF (overrun) → clear the whole vector, pulse `sequenceError`, stay in IDLE.
  - AA, FA, FE, EE → ignored.
  - Any other byte → make(code, ext=0), stay in IDLE.
- From EXT: F0→EXTBRK; any other byte → make(code, ext=1) then IDLE.
- From BRK: any byte → break(code, ext=0) then IDLE.
- From EXTBRK: any byte → break(code, ext=1) then IDLE.
- PAUSE: each byte decrements the counter; when it reaches 0, return to IDLE. No key updates occur in PAUSE.
- make: if (ext, code) maps to key k, set bit k. If bit k was already 1 (typematic repeat), no `newPress` pulse. Unmapped codes are ignored.
- break: if mapped, clear bit k. Clearing an already-clear bit is harmless.
- Mapping is a fixed lookup:
  - Spacebar 29 → `` `keySpacebar ``.
  - Backslash 5D → `` `keyBackslash ``.
  - R 2D → `` `keyR ``.
  - Piano keys per the key-index macros.
  - E0-prefixed codes are distinct from the same code without the prefix; none are mapped by default.
- Timeout: in BRK, EXT or EXTBRK, a counter increments on every cycle without a byte. When it reaches `PREFIX_TIMEOUT`-1, the parser returns to IDLE, pulses `sequenceError` and makes no key change. The counter clears on every byte and on entry to IDLE. PAUSE is also subject to the timeout.

## Timing
- Byte accepted at cycle t → `inputStateStorage` and `newPress` reflect it at t+1. Latency is 1 cycle; all outputs are registered.
- `newPress` and `sequenceError` are high for exactly one cycle and are otherwise 0.
- Back-to-back strobes are each processed; no byte is dropped.
- A strobe in the same cycle as the timeout expiry: the byte wins. It is processed in the current state and no error is raised.
- `resetn` mid-sequence: the parser returns to IDLE and the vector clears on the next edge. The tail of the interrupted sequence is then parsed from IDLE.
- Overrun clear and new-press: clearing never produces `newPress`.

## Structure
- `` `NUMBEROFKEYBOARDINPUTS ``, the `` `keyX `` indices, the parser state encodings and the special scan-code byte values belong in DefineMacros.vh.
- Sub-module `scancode_to_key_index`: combinational (ext, code) → (hit, index).

## Test plan
- Byte 29 strobed → bit `` `keySpacebar `` = 1 and `newPress` pulses at t+1. Then F0, 29 → bit clears, no pulse.
- 2D, 2D, 2D (typematic) → bit `` `keyR `` = 1, with `newPress` pulsed once only.
- E0 29 → no change. Then E0 F0 29 → no change, and `` `keySpacebar `` is unaffected throughout.
- Press 5D, then send E1 14 77 E1 F0 14 F0 77 → `` `keyBackslash `` stays 1, no other bit changes, parser is in IDLE after the 8th byte.
- F0 followed by `PREFIX_TIMEOUT` idle cycles → `sequenceError` pulses. A following 29 is treated as a make.
- Hold spacebar, then FF → vector = 0 and `sequenceError` pulses. Separately, assert `resetn` between F0 and 29 → 29 is treated as a make after reset.
